// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage: XLEN, reset PC default,
// fetch FSM state encoding and a word-alignment helper.
package fetch_unit_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      SEQ     = 2'd0,
      TAKEN   = 2'd1,
      RECOVER = 2'd2
   } fetch_state_t;

   // Clear the byte-offset bits of an instruction address.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: HCU/Decode/Execute control into the fetch unit, PC and
// status back out.
//   master: drives StallF, branch_D, jump_D, PC_D, imm_D, mispredict_E, PCPlus4_E
//   slave : drives PC_F, PCPlus4_F, branched_flag_F, misalign_err,
//           branch_cnt, mispredict_cnt
interface fetch_unit_if #(
   parameter int unsigned CNT_W = 16
);
   import fetch_unit_pkg::*;

   logic             StallF;
   logic             branch_D;
   logic             jump_D;
   logic [XLEN-1:0]  PC_D;
   logic [XLEN-1:0]  imm_D;
   logic             mispredict_E;
   logic [XLEN-1:0]  PCPlus4_E;
   logic [XLEN-1:0]  PC_F;
   logic [XLEN-1:0]  PCPlus4_F;
   logic             branched_flag_F;
   logic             misalign_err;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispredict_cnt;

   modport master (
      output StallF, branch_D, jump_D, PC_D, imm_D, mispredict_E, PCPlus4_E,
      input  PC_F, PCPlus4_F, branched_flag_F, misalign_err, branch_cnt, mispredict_cnt
   );

   modport slave (
      input  StallF, branch_D, jump_D, PC_D, imm_D, mispredict_E, PCPlus4_E,
      output PC_F, PCPlus4_F, branched_flag_F, misalign_err, branch_cnt, mispredict_cnt
   );

endinterface

// File: rtl/fetch_unit_sat_counter.sv
// Saturating up-counter used for fetch performance statistics.
//   clk, nreset : clock, async active-low reset
//   inc         : count one event this cycle
//   o_count     : current count, holds at all-ones
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic         inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_count <= '0;
      end else if (inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Fetch-stage PC controller: next-PC selection (mispredict recovery, stall,
// static predict-taken redirect, sequential), fetch FSM and statistics.
//   clk, nreset : clock, async active-low reset
//   bus         : fetch_unit_if.slave (HCU/Decode/Execute in, PC/status out)
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned     CNT_W    = 16
) (
   input  logic        clk,
   input  logic        nreset,
   fetch_unit_if.slave bus
);

   fetch_state_t    r_state;
   fetch_state_t    w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_nxt;
   logic [XLEN-1:0] w_target;
   logic            r_branched;
   logic            r_misalign;
   logic            w_misalign;
   logic            w_pred_ok;
   logic            w_pred_redirect;

   assign w_target = bus.PC_D + bus.imm_D;

   // A Decode branch/jump redirects only once, and never right after a flush.
   assign w_pred_ok = (bus.branch_D || bus.jump_D) && !r_branched && (r_state != RECOVER);

   // Next-PC priority: mispredict > stall > predicted redirect > sequential.
   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_misalign      = 1'b0;
      w_pred_redirect = 1'b0;
      if (bus.mispredict_E) begin
         w_pc_nxt    = align_word(bus.PCPlus4_E);
         w_misalign  = |bus.PCPlus4_E[1:0];
         w_state_nxt = RECOVER;
      end else if (bus.StallF) begin
         // TAKEN waits for Decode to advance; RECOVER lasts one cycle only.
         if (r_state == RECOVER) begin
            w_state_nxt = SEQ;
         end
      end else if (w_pred_ok) begin
         w_pc_nxt        = align_word(w_target);
         w_misalign      = |w_target[1:0];
         w_pred_redirect = 1'b1;
         w_state_nxt     = TAKEN;
      end else begin
         w_pc_nxt    = r_pc + XLEN'(4);
         w_state_nxt = SEQ;
      end
   end

   // State, PC and status registers.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state    <= SEQ;
         r_pc       <= RESET_PC;
         r_branched <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_branched <= (w_state_nxt == TAKEN);
         r_misalign <= r_misalign | w_misalign;
      end
   end

   assign bus.PC_F            = r_pc;
   assign bus.PCPlus4_F       = r_pc + XLEN'(4);
   assign bus.branched_flag_F = r_branched;
   assign bus.misalign_err    = r_misalign;

   sat_counter #(.W(CNT_W)) u_branch_cnt (
      .clk     (clk),
      .nreset  (nreset),
      .inc     (w_pred_redirect),
      .o_count (bus.branch_cnt)
   );

   sat_counter #(.W(CNT_W)) u_mispredict_cnt (
      .clk     (clk),
      .nreset  (nreset),
      .inc     (bus.mispredict_E),
      .o_count (bus.mispredict_cnt)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic against a behavioural next-PC model; a narrow-counter instance
// exercises saturation.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int unsigned SAT_W   = 3;
   localparam int          CNT_MAX = 65535;
   localparam int          SAT_MAX = 7;

   logic clk = 1'b0;
   logic nreset;

   fetch_unit_if #(.CNT_W(16))    bus ();
   fetch_unit_if #(.CNT_W(SAT_W)) bus_s ();

   fetch_unit #(.RESET_PC(32'h0), .CNT_W(16)) u_dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (bus)
   );

   fetch_unit #(.RESET_PC(32'h0), .CNT_W(SAT_W)) u_dut_sat (
      .clk    (clk),
      .nreset (nreset),
      .bus    (bus_s)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model of the main instance.
   logic [31:0] m_pc;
   bit          m_flag;     // predicted redirect taken, Decode not yet advanced
   bit          m_flushed;  // previous edge was a mispredict
   bit          m_mis;
   int          m_bcnt;
   int          m_mcnt;

   function automatic void model_reset();
      m_pc = 32'h0; m_flag = 0; m_flushed = 0; m_mis = 0; m_bcnt = 0; m_mcnt = 0;
   endfunction

   function automatic void model_step();
      logic [31:0] tgt;
      if (bus.mispredict_E) begin
         if ((bus.PCPlus4_E % 4) != 0) m_mis = 1;
         m_pc      = bus.PCPlus4_E - (bus.PCPlus4_E % 4);
         m_mcnt    = (m_mcnt < CNT_MAX) ? m_mcnt + 1 : CNT_MAX;
         m_flag    = 0;
         m_flushed = 1;
      end else if (bus.StallF) begin
         m_flushed = 0;
      end else if ((bus.branch_D || bus.jump_D) && !m_flag && !m_flushed) begin
         tgt = bus.PC_D + bus.imm_D;
         if ((tgt % 4) != 0) m_mis = 1;
         m_pc   = tgt - (tgt % 4);
         m_bcnt = (m_bcnt < CNT_MAX) ? m_bcnt + 1 : CNT_MAX;
         m_flag = 1;
      end else begin
         m_pc      = m_pc + 32'd4;
         m_flag    = 0;
         m_flushed = 0;
      end
   endfunction

   task automatic set_idle();
      bus.StallF = 0; bus.branch_D = 0; bus.jump_D = 0; bus.PC_D = '0; bus.imm_D = '0;
      bus.mispredict_E = 0; bus.PCPlus4_E = '0;
      bus_s.StallF = 0; bus_s.branch_D = 0; bus_s.jump_D = 0; bus_s.PC_D = '0; bus_s.imm_D = '0;
      bus_s.mispredict_E = 0; bus_s.PCPlus4_E = '0;
   endtask

   // Inputs are driven at negedge; one rising edge, then back to negedge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      set_idle();
      nreset = 0;
      model_reset();
      #3;
      n_checks++; if (bus.PC_F !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want %h", bus.PC_F, 32'h0); end
      n_checks++; if (bus.PCPlus4_F !== 32'h4) begin n_fail++; $display("FAIL reset_pcplus4 got %h want %h", bus.PCPlus4_F, 32'h4); end
      n_checks++; if (bus.branched_flag_F !== 1'b0) begin n_fail++; $display("FAIL reset_flag got %b want 0", bus.branched_flag_F); end
      n_checks++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %b want 0", bus.misalign_err); end
      n_checks++; if (bus.branch_cnt !== 16'h0 || bus.mispredict_cnt !== 16'h0) begin
         n_fail++; $display("FAIL reset_counters got %h/%h want 0/0", bus.branch_cnt, bus.mispredict_cnt); end
      @(negedge clk);
      nreset = 1;
      for (int i = 1; i <= 2; i++) begin
         cycle();
         n_checks++; if (bus.PC_F !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_pc[%0d] got %h want %h", i, bus.PC_F, 32'(i * 4)); end
         n_checks++; if (bus.branched_flag_F !== 1'b0) begin n_fail++; $display("FAIL seq_flag[%0d] got %b want 0", i, bus.branched_flag_F); end
      end
   endtask

   task automatic test_branch();
      bus.branch_D = 1; bus.PC_D = 32'h40; bus.imm_D = 32'h20;
      cycle();
      n_checks++; if (bus.PC_F !== 32'h60) begin n_fail++; $display("FAIL branch_target got %h want %h", bus.PC_F, 32'h60); end
      n_checks++; if (bus.branched_flag_F !== 1'b1) begin n_fail++; $display("FAIL branch_flag_set got %b want 1", bus.branched_flag_F); end
      n_checks++; if (bus.branch_cnt !== 16'(m_bcnt)) begin n_fail++; $display("FAIL branch_cnt got %0d want %0d", bus.branch_cnt, m_bcnt); end
      bus.branch_D = 0;
      cycle();
      n_checks++; if (bus.branched_flag_F !== 1'b0) begin n_fail++; $display("FAIL branch_flag_clear got %b want 0", bus.branched_flag_F); end
      n_checks++; if (bus.PC_F !== 32'h64) begin n_fail++; $display("FAIL branch_after got %h want %h", bus.PC_F, 32'h64); end
   endtask

   task automatic test_mispredict();
      // Mispredict under stall, with a branch in Decode that must be flushed.
      bus.StallF = 1; bus.mispredict_E = 1; bus.PCPlus4_E = 32'h44;
      bus.branch_D = 1; bus.PC_D = 32'h200; bus.imm_D = 32'h80;
      cycle();
      n_checks++; if (bus.PC_F !== 32'h44) begin n_fail++; $display("FAIL mp_pc got %h want %h", bus.PC_F, 32'h44); end
      n_checks++; if (bus.branched_flag_F !== 1'b0) begin n_fail++; $display("FAIL mp_flag got %b want 0", bus.branched_flag_F); end
      n_checks++; if (bus.mispredict_cnt !== 16'(m_mcnt)) begin n_fail++; $display("FAIL mp_cnt got %0d want %0d", bus.mispredict_cnt, m_mcnt); end
      n_checks++; if (bus.branch_cnt !== 16'(m_bcnt)) begin n_fail++; $display("FAIL mp_flushed_branch got %0d want %0d", bus.branch_cnt, m_bcnt); end
      // Recovery cycle suppresses the predicted redirect.
      bus.StallF = 0; bus.mispredict_E = 0; bus.PC_D = 32'h44; bus.imm_D = 32'h100;
      cycle();
      n_checks++; if (bus.PC_F !== 32'h48) begin n_fail++; $display("FAIL recover_suppress got %h want %h", bus.PC_F, 32'h48); end
      // Back in sequential mode, the redirect is honoured.
      cycle();
      n_checks++; if (bus.PC_F !== 32'h144 || bus.branched_flag_F !== 1'b1) begin
         n_fail++; $display("FAIL recover_to_seq got %h/%b want %h/1", bus.PC_F, bus.branched_flag_F, 32'h144); end
      set_idle();
      cycle();
   endtask

   task automatic test_stall();
      bus.mispredict_E = 1; bus.PCPlus4_E = 32'h10;
      cycle();
      bus.mispredict_E = 0; bus.StallF = 1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_checks++; if (bus.PC_F !== 32'h10) begin n_fail++; $display("FAIL stall_hold[%0d] got %h want %h", i, bus.PC_F, 32'h10); end
      end
      bus.StallF = 0;
      cycle();
      n_checks++; if (bus.PC_F !== 32'h14) begin n_fail++; $display("FAIL stall_release got %h want %h", bus.PC_F, 32'h14); end
      // Flag persists while Decode is stalled after a redirect.
      bus.branch_D = 1; bus.PC_D = 32'h14; bus.imm_D = 32'h30;
      cycle();
      bus.StallF = 1;
      for (int i = 0; i < 2; i++) begin
         cycle();
         n_checks++; if (bus.branched_flag_F !== 1'b1 || bus.PC_F !== 32'h44) begin
            n_fail++; $display("FAIL taken_stall[%0d] got %h/%b want %h/1", i, bus.PC_F, bus.branched_flag_F, 32'h44); end
      end
      bus.StallF = 0;
      cycle();
      n_checks++; if (bus.branched_flag_F !== 1'b0 || bus.PC_F !== 32'h48) begin
         n_fail++; $display("FAIL taken_release got %h/%b want %h/0", bus.PC_F, bus.branched_flag_F, 32'h48); end
      set_idle();
   endtask

   task automatic test_misalign();
      bus.jump_D = 1; bus.PC_D = 32'hF0; bus.imm_D = 32'h12;
      cycle();
      n_checks++; if (bus.PC_F !== 32'h100) begin n_fail++; $display("FAIL misalign_pc got %h want %h", bus.PC_F, 32'h100); end
      n_checks++; if (bus.misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_set got %b want 1", bus.misalign_err); end
      set_idle();
      for (int i = 0; i < 3; i++) cycle();
      n_checks++; if (bus.misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_sticky got %b want 1", bus.misalign_err); end
   endtask

   task automatic test_async_reset();
      bus.branch_D = 1; bus.PC_D = 32'h300; bus.imm_D = 32'h40;
      cycle();
      #2;
      nreset = 0;
      #1;
      model_reset();
      n_checks++; if (bus.PC_F !== 32'h0 || bus.branched_flag_F !== 1'b0) begin
         n_fail++; $display("FAIL async_pc_flag got %h/%b want 0/0", bus.PC_F, bus.branched_flag_F); end
      n_checks++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL async_misalign got %b want 0", bus.misalign_err); end
      n_checks++; if (bus.branch_cnt !== 16'h0 || bus.mispredict_cnt !== 16'h0 || bus_s.branch_cnt !== 3'h0 || bus_s.mispredict_cnt !== 3'h0) begin
         n_fail++; $display("FAIL async_counters got %h/%h/%h/%h want all 0", bus.branch_cnt, bus.mispredict_cnt, bus_s.branch_cnt, bus_s.mispredict_cnt); end
      set_idle();
      @(negedge clk);
      nreset = 1;
      cycle();
      n_checks++; if (bus.PC_F !== 32'h4) begin n_fail++; $display("FAIL async_first_fetch got %h want %h", bus.PC_F, 32'h4); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bus.mispredict_E = ($urandom_range(7) == 0);
         bus.StallF       = ($urandom_range(3) == 0);
         bus.branch_D     = ($urandom_range(3) == 0);
         bus.jump_D       = ($urandom_range(7) == 0);
         bus.PC_D         = $urandom & 32'hFFFF_FFFC;
         bus.imm_D        = ($urandom_range(15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         bus.PCPlus4_E    = $urandom & 32'hFFFF_FFFC;
         cycle();
         n_checks++; if (bus.PC_F !== m_pc) begin n_fail++; $display("FAIL rand_pc[%0d] got %h want %h", i, bus.PC_F, m_pc); end
         n_checks++; if (bus.PCPlus4_F !== m_pc + 32'd4) begin n_fail++; $display("FAIL rand_pcplus4[%0d] got %h want %h", i, bus.PCPlus4_F, m_pc + 32'd4); end
         n_checks++; if (bus.branched_flag_F !== m_flag) begin n_fail++; $display("FAIL rand_flag[%0d] got %b want %b", i, bus.branched_flag_F, m_flag); end
         n_checks++; if (bus.misalign_err !== m_mis) begin n_fail++; $display("FAIL rand_misalign[%0d] got %b want %b", i, bus.misalign_err, m_mis); end
         n_checks++; if (bus.branch_cnt !== 16'(m_bcnt) || bus.mispredict_cnt !== 16'(m_mcnt)) begin
            n_fail++; $display("FAIL rand_cnt[%0d] got %0d/%0d want %0d/%0d", i, bus.branch_cnt, bus.mispredict_cnt, m_bcnt, m_mcnt); end
      end
      set_idle();
   endtask

   task automatic test_saturate();
      int exp;
      // Held branch redirects on every other edge (SEQ -> TAKEN -> SEQ ...).
      bus_s.branch_D = 1; bus_s.PC_D = 32'h0; bus_s.imm_D = 32'h40;
      for (int i = 1; i <= 20; i++) begin
         cycle();
         exp = (i + 1) / 2;
         if (exp > SAT_MAX) exp = SAT_MAX;
         n_checks++; if (bus_s.branch_cnt !== SAT_W'(exp)) begin
            n_fail++; $display("FAIL sat_branch[%0d] got %0d want %0d", i, bus_s.branch_cnt, exp); end
      end
      bus_s.branch_D = 0; bus_s.mispredict_E = 1; bus_s.PCPlus4_E = 32'h80;
      for (int i = 1; i <= 10; i++) begin
         cycle();
         exp = (i > SAT_MAX) ? SAT_MAX : i;
         n_checks++; if (bus_s.mispredict_cnt !== SAT_W'(exp)) begin
            n_fail++; $display("FAIL sat_mispredict[%0d] got %0d want %0d", i, bus_s.mispredict_cnt, exp); end
      end
      set_idle();
   endtask

   initial begin
      test_reset();
      test_branch();
      test_mispredict();
      test_stall();
      test_misalign();
      test_async_reset();
      test_random();
      test_saturate();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
